// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os
// UART receiver with its own oversampling baud generator. Each bit is
// sampled three times around mid-bit, and the majority of those three
// samples decides the bit value. Parity and the number of stop bits are set
// at run time. The block reports framing, parity and overrun errors, and it
// hands completed words to the bus side over a valid/ready handshake.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   baud_div_i   clk cycles per oversample tick (0 behaves as 1)
//   par_en_i     a parity bit follows the data bits
//   par_odd_i    1 = odd parity, 0 = even parity
//   stop2_i      check two stop bits
//   rxd_i        asynchronous serial input, idles high
//   rx_ready_i   consumer accepts the held word
//   rx_data_o    received word (the line sends it LSB first)
//   rx_valid_o   rx_data_o and the error flags are valid; held until accepted
//   frame_err_o  a stop bit of the held word was sampled low
//   par_err_o    parity mismatch on the held word
//   overrun_o    sticky; a completed word was dropped because one was held
//   busy_o       receiver is inside a frame
// ---------------------------------------------------------------------------
module uart_rx_os #(
  parameter int DATA_W = 8,
  parameter int OSR    = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic              par_en_i,
  input  logic              par_odd_i,
  input  logic              stop2_i,
  input  logic              rxd_i,
  input  logic              rx_ready_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              frame_err_o,
  output logic              par_err_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int OS_W  = $clog2(OSR);
  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [OS_W-1:0]  OS_S0    = OS_W'(OSR/2 - 1);
  localparam logic [OS_W-1:0]  OS_S1    = OS_W'(OSR/2);
  localparam logic [OS_W-1:0]  OS_S2    = OS_W'(OSR/2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OSR - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_e;

  state_e             state_q;
  logic               rx_meta_q, rxs_q, rxs_prev_q;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]    os_cnt_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic               s0_q, s1_q;
  logic [DATA_W-1:0]  shreg_q;
  logic               fe_acc_q, par_acc_q;
  logic [DATA_W-1:0]  rx_data_q;
  logic               rx_valid_q, frame_err_q, par_err_q, overrun_q;

  logic [DIV_W-1:0]   div_eff, div_last;
  logic               tick, start_edge, vote, dec_tick, end_tick;
  logic               complete, frame_err_d;

  // Two-flop synchroniser plus one extra stage so that a falling edge can be
  // seen on the synchronised line. All stages reset to the idle-high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rxd_i;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Tick generation and the bit decision. The third sample is not stored: it
  // is the live synchronised value on the decision tick itself.
  always_comb begin
    div_eff     = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
    div_last    = div_eff - DIV_W'(1);
    tick        = (div_cnt_q >= div_last);
    start_edge  = rxs_prev_q & ~rxs_q;
    vote        = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    dec_tick    = tick && (os_cnt_q == OS_S2);
    end_tick    = tick && (os_cnt_q == OS_LAST);
    complete    = dec_tick &&
                  (((state_q == S_STOP1) && !stop2_i) || (state_q == S_STOP2));
    frame_err_d = (state_q == S_STOP2) ? (fe_acc_q | ~vote) : ~vote;
    if ((state_q == S_IDLE) && start_edge) begin
      div_cnt_d = '0;
    end else if (tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // Receive FSM and output register. A frame finishes at the mid-stop
  // decision so that a start edge in the second half of the stop bit is
  // still caught. The finished word is loaded on that same edge, which makes
  // rx_valid rise on the clk where busy falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      shreg_q     <= '0;
      fe_acc_q    <= 1'b0;
      par_acc_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;

      if (state_q == S_IDLE) begin
        os_cnt_q <= '0;
      end else if (tick) begin
        os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
      end

      if (tick && (os_cnt_q == OS_S0)) s0_q <= rxs_q;
      if (tick && (os_cnt_q == OS_S1)) s1_q <= rxs_q;

      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q   <= S_START;
            bit_idx_q <= '0;
            fe_acc_q  <= 1'b0;
            par_acc_q <= 1'b0;
          end
        end
        S_START: begin
          // A high majority means the edge was a glitch, not a start bit.
          if (dec_tick && vote) begin
            state_q <= S_IDLE;
          end else if (end_tick) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (dec_tick) shreg_q <= {vote, shreg_q[DATA_W-1:1]};
          if (end_tick) begin
            if (bit_idx_q == IDX_LAST) begin
              state_q <= par_en_i ? S_PARITY : S_STOP1;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (dec_tick) par_acc_q <= (^shreg_q) ^ vote ^ par_odd_i;
          if (end_tick) state_q <= S_STOP1;
        end
        S_STOP1: begin
          if (dec_tick) begin
            fe_acc_q <= ~vote;
            if (!stop2_i) state_q <= S_IDLE;
          end else if (end_tick) begin
            state_q <= S_STOP2;
          end
        end
        S_STOP2: begin
          if (dec_tick) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // A finished word either replaces the held one (free or being accepted
      // this cycle) or is dropped and reported as an overrun.
      if (complete) begin
        if (!rx_valid_q || rx_ready_i) begin
          rx_data_q   <= shreg_q;
          frame_err_q <= frame_err_d;
          par_err_q   <= par_acc_q;
          rx_valid_q  <= 1'b1;
          if (rx_valid_q) overrun_q <= 1'b0;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign par_err_o   = par_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_os
// Self-checking bench for uart_rx_os. Two instances are built: an 8-bit one
// with run-time configuration, and a 7-bit one fixed to two stop bits.
// Frames are serialised bit by bit. The expected word and flags come from the
// frame contents, and they are queued; monitors pop and compare whenever a
// word is handed over.
// ---------------------------------------------------------------------------
module tb_uart_rx_os;
  localparam int OSR = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baudDiv8;
  logic        parEn8, parOdd8, stop2_8, rxd8, rxReady8;
  logic [7:0]  rxData8;
  logic        rxValid8, frameErr8, parErr8, overrun8, busy8;
  logic        rxd7;
  logic [6:0]  rxData7;
  logic        rxValid7, frameErr7, parErr7, overrun7, busy7;

  exp_t q8[$];
  exp_t q7[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   cyc = 0;
  int   startCyc8 = 0;
  int   riseCyc8 = 0;
  int   delivered8 = 0;
  int   delivered7 = 0;
  bit   readyMode = 1'b0;
  logic prevValid8 = 1'b0;
  logic prevValid7 = 1'b0;

  uart_rx_os #(.DATA_W(8), .OSR(OSR), .DIV_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .baud_div_i(baudDiv8), .par_en_i(parEn8),
    .par_odd_i(parOdd8), .stop2_i(stop2_8), .rxd_i(rxd8),
    .rx_ready_i(rxReady8), .rx_data_o(rxData8), .rx_valid_o(rxValid8),
    .frame_err_o(frameErr8), .par_err_o(parErr8), .overrun_o(overrun8),
    .busy_o(busy8)
  );

  uart_rx_os #(.DATA_W(7), .OSR(OSR), .DIV_W(16)) dut7 (
    .clk(clk), .rst_n(rst_n), .baud_div_i(16'd2), .par_en_i(1'b0),
    .par_odd_i(1'b0), .stop2_i(1'b1), .rxd_i(rxd7), .rx_ready_i(1'b1),
    .rx_data_o(rxData7), .rx_valid_o(rxValid7), .frame_err_o(frameErr7),
    .par_err_o(parErr7), .overrun_o(overrun7), .busy_o(busy7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Random consumer back-pressure, driven just after the clock edge.
  always @(posedge clk) begin
    if (readyMode) begin
      #2;
      rxReady8 = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor for the 8-bit instance: pops on every accepted word.
  exp_t e8;
  always @(negedge clk) begin
    if (rxValid8 && !prevValid8) begin
      riseCyc8 = cyc;
      checkOutput("busy8_low_at_valid", 32'(busy8), 32'd0);
    end
    prevValid8 = rxValid8;
    if (rxValid8 && rxReady8) begin
      if (q8.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_word8: got 0x%0h, expected no word", rxData8);
      end else begin
        e8 = q8.pop_front();
        checkOutput("data8", 32'(rxData8), 32'(e8.data[7:0]));
        checkOutput("frame_err8", 32'(frameErr8), 32'(e8.fe));
        checkOutput("par_err8", 32'(parErr8), 32'(e8.pe));
        delivered8++;
      end
    end
  end

  // Monitor for the 7-bit instance (its rx_ready is tied high).
  exp_t e7;
  always @(negedge clk) begin
    if (rxValid7 && !prevValid7) checkOutput("busy7_low_at_valid", 32'(busy7), 32'd0);
    prevValid7 = rxValid7;
    if (rxValid7) begin
      if (q7.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_word7: got 0x%0h, expected no word", rxData7);
      end else begin
        e7 = q7.pop_front();
        checkOutput("data7", 32'(rxData7), 32'(e7.data[6:0]));
        checkOutput("frame_err7", 32'(frameErr7), 32'(e7.fe));
        checkOutput("par_err7", 32'(parErr7), 32'(e7.pe));
        delivered7++;
      end
    end
  end

  task automatic driveRx(input bit which, input logic v);
    if (which) rxd7 = v;
    else rxd8 = v;
  endtask

  task automatic holdBits(input bit which, input logic v, input int n);
    driveRx(which, v);
    repeat (n) @(negedge clk);
  endtask

  // Serialise one frame and, when a word is expected, queue the expected
  // result. The noise injection offsets assume a 64-clk bit (baud_div=4):
  // a one-tick inversion lands on the middle of the three samples only.
  task automatic applyStimulus(input bit which, input logic [8:0] data,
                               input bit pbitFlip, input logic [1:0] stopBits,
                               input bit expectWord, input int noiseBit);
    int   nbits, bitClk, ones;
    bit   pen, pod, s2, pbit;
    exp_t e;
    nbits  = which ? 7 : 8;
    pen    = which ? 1'b0 : parEn8;
    pod    = which ? 1'b0 : parOdd8;
    s2     = which ? 1'b1 : stop2_8;
    bitClk = which ? 2 * OSR : ((baudDiv8 == 16'd0) ? 1 : int'(baudDiv8)) * OSR;
    ones   = 0;
    for (int i = 0; i < nbits; i++) ones += int'(data[i]);
    pbit   = ones[0] ^ pod ^ pbitFlip;
    e.data = which ? {2'b00, data[6:0]} : {1'b0, data[7:0]};
    e.pe   = pen && (((ones + int'(pbit)) % 2) != int'(pod));
    e.fe   = !stopBits[0] || (s2 && !stopBits[1]);
    if (expectWord) begin
      if (which) q7.push_back(e);
      else q8.push_back(e);
    end
    if (!which) startCyc8 = cyc;
    holdBits(which, 1'b0, bitClk);
    for (int i = 0; i < nbits; i++) begin
      if (i == noiseBit) begin
        holdBits(which, data[i], 34);
        holdBits(which, ~data[i], 4);
        holdBits(which, data[i], bitClk - 38);
      end else begin
        holdBits(which, data[i], bitClk);
      end
    end
    if (pen) holdBits(which, pbit, bitClk);
    holdBits(which, stopBits[0], bitClk);
    if (s2) holdBits(which, stopBits[1], bitClk);
    holdBits(which, 1'b1, 2 * bitClk);
  endtask

  initial begin
    int d0, lat;
    rst_n = 1'b0;
    rxd8 = 1'b1;
    rxd7 = 1'b1;
    rxReady8 = 1'b1;
    baudDiv8 = 16'd4;
    parEn8 = 1'b0;
    parOdd8 = 1'b0;
    stop2_8 = 1'b0;
    #23;
    checkOutput("reset_rx_data", 32'(rxData8), 32'd0);
    checkOutput("reset_rx_valid", 32'(rxValid8), 32'd0);
    checkOutput("reset_frame_err", 32'(frameErr8), 32'd0);
    checkOutput("reset_par_err", 32'(parErr8), 32'd0);
    checkOutput("reset_overrun", 32'(overrun8), 32'd0);
    checkOutput("reset_busy", 32'(busy8), 32'd0);
    checkOutput("reset_busy7", 32'(busy7), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0x55 and the completion latency of about 9.6 bit times.
    applyStimulus(0, 9'h055, 1'b0, 2'b11, 1'b1, -1);
    lat = riseCyc8 - startCyc8;
    testsRun++;
    if (lat < 600 || lat > 630) begin
      testsFailed++;
      $display("[TB] FAIL latency_8n1: got %0d clk, expected 600..630 clk", lat);
    end

    // Even parity with a wrong parity bit, then odd parity with the same bit.
    parEn8 = 1'b1;
    applyStimulus(0, 9'h0A5, 1'b1, 2'b11, 1'b1, -1);
    parOdd8 = 1'b1;
    applyStimulus(0, 9'h0A5, 1'b0, 2'b11, 1'b1, -1);
    parEn8 = 1'b0;
    parOdd8 = 1'b0;

    // Glitch shorter than half a bit is rejected by the start check.
    d0 = delivered8;
    holdBits(0, 1'b0, 12);
    checkOutput("glitch_busy_high", 32'(busy8), 32'd1);
    holdBits(0, 1'b1, 64);
    checkOutput("glitch_busy_low", 32'(busy8), 32'd0);
    checkOutput("glitch_no_word", 32'(delivered8 - d0), 32'd0);

    // A single inverted sample in data bit 3 is out-voted.
    applyStimulus(0, 9'h00F, 1'b0, 2'b11, 1'b1, 3);

    // Bad stop bit, then a 20-bit break gives exactly one zero word.
    d0 = delivered8;
    applyStimulus(0, 9'h03C, 1'b0, 2'b10, 1'b1, -1);
    q8.push_back('{data: 9'h000, fe: 1'b1, pe: 1'b0});
    holdBits(0, 1'b0, 20 * 64);
    checkOutput("break_word_count", 32'(delivered8 - d0), 32'd2);
    checkOutput("break_busy_low", 32'(busy8), 32'd0);
    holdBits(0, 1'b1, 128);
    applyStimulus(0, 9'h05A, 1'b0, 2'b11, 1'b1, -1);

    // Overrun: the held word survives while later words are dropped.
    @(posedge clk);
    #2 rxReady8 = 1'b0;
    applyStimulus(0, 9'h011, 1'b0, 2'b11, 1'b1, -1);
    checkOutput("ovr_valid_held", 32'(rxValid8), 32'd1);
    checkOutput("ovr_none_yet", 32'(overrun8), 32'd0);
    applyStimulus(0, 9'h022, 1'b0, 2'b11, 1'b0, -1);
    checkOutput("ovr_set", 32'(overrun8), 32'd1);
    checkOutput("ovr_data_kept_22", 32'(rxData8), 32'h11);
    applyStimulus(0, 9'h033, 1'b0, 2'b11, 1'b0, -1);
    checkOutput("ovr_data_kept_33", 32'(rxData8), 32'h11);
    @(posedge clk);
    #2 rxReady8 = 1'b1;
    @(posedge clk);
    #2 rxReady8 = 1'b0;
    checkOutput("ovr_valid_cleared", 32'(rxValid8), 32'd0);
    checkOutput("ovr_cleared", 32'(overrun8), 32'd0);
    rxReady8 = 1'b1;
    applyStimulus(0, 9'h044, 1'b0, 2'b11, 1'b1, -1);
    checkOutput("ovr_after_44", 32'(overrun8), 32'd0);

    // Asynchronous reset in the middle of a frame discards it.
    d0 = delivered8;
    holdBits(0, 1'b0, 200);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(busy8), 32'd0);
    checkOutput("midreset_valid", 32'(rxValid8), 32'd0);
    rxd8 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (128) @(negedge clk);
    checkOutput("midreset_no_word", 32'(delivered8 - d0), 32'd0);

    // Randomised frames, configurations and back-pressure.
    readyMode = 1'b1;
    for (int n = 0; n < 16; n++) begin
      baudDiv8 = 16'($urandom_range(0, 4));
      parEn8   = 1'($urandom_range(0, 1));
      parOdd8  = 1'($urandom_range(0, 1));
      stop2_8  = 1'($urandom_range(0, 1));
      applyStimulus(0, 9'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                    {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                    1'b1, -1);
    end
    @(negedge clk);
    readyMode = 1'b0;
    @(posedge clk);
    #2 rxReady8 = 1'b1;
    repeat (20) @(negedge clk);

    // 7-bit instance with two stop bits, including a bad second stop bit.
    applyStimulus(1, 9'h07F, 1'b0, 2'b11, 1'b1, -1);
    applyStimulus(1, 9'h02A, 1'b0, 2'b01, 1'b1, -1);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1, 9'($urandom_range(0, 127)), 1'b0,
                    {($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0)},
                    1'b1, -1);
    end

    repeat (20) @(negedge clk);
    checkOutput("queue8_drained", 32'(q8.size()), 32'd0);
    checkOutput("queue7_drained", 32'(q7.size()), 32'd0);
    checkOutput("words7_delivered", 32'(delivered7), 32'd5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised UART receiver: next generation of the fixed 8-bit, externally-ticked receiver.
- Owns its oversampling baud generator and does 3-sample majority voting per bit.
- Supports run-time parity and stop-bit configuration; reports framing, parity and overrun errors.
- Sits between the pad-side rxd pin and the bus-side UART register block; delivers words over a valid/ready handshake.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- OSR, 16, oversample ticks per bit; even, >= 8.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- baud_div  in  DIV_W  clk cycles per oversample tick; 0 treated as 1
- par_en  in  1  1 = parity bit present after data
- par_odd  in  1  1 = odd parity, 0 = even (ignored if par_en=0)
- stop2  in  1  1 = two stop bits checked
- rxd  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_W  received word, LSB first on the line
- rx_valid  out  1  rx_data/flags valid; held until accepted
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready
- frame_err  out  1  stop bit sampled 0 for the held word
- par_err  out  1  parity mismatch for the held word
- overrun  out  1  sticky; a completed word was dropped
- busy  out  1  1 while not in IDLE

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, par_err=0, overrun=0, busy=0, state=IDLE, counters=0, rxd synchroniser=1.
- rxd passes through a 2-flop synchroniser (rxs). Falling edge = rxs previous 1, current 0.
- Tick generator: div_cnt counts 0..baud_div-1; tick pulses one clk when div_cnt wraps. div_cnt and os_cnt clear on the start edge detected in IDLE.
- os_cnt counts ticks 0..OSR-1 within each bit, then wraps to 0 at the next bit boundary.
- Samples are taken at os_cnt = OSR/2-1, OSR/2 and OSR/2+1. The bit value is the majority of the three; the decision is made on the OSR/2+1 tick.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
  - IDLE: on falling edge, go to START; busy asserts the next clk.
  - START: a majority of 1 is a false start; go to IDLE with no output. A majority of 0 means continue; DATA follows at the end of the bit.
  - DATA: DATA_W bits, shifted in LSB first; bit index 0..DATA_W-1. After the last bit, go to PARITY if par_en=1, else STOP1.
  - PARITY: par_err_n = XOR(data, parity bit) XOR par_odd. Even parity needs the total XOR to be 0; odd parity needs it to be 1.
  - STOP1: frame_err_n = ~bit. If stop2=1, go to STOP2; else the frame completes at this decision tick.
  - STOP2: frame_err_n |= ~bit; the frame completes at its decision tick.
- Frame completion: the next state is IDLE immediately, at mid-stop, so a start edge in the second half of the stop bit is caught.
- Output register is loaded the clk after the completion tick:
  - rx_valid=0, or rx_valid & rx_ready in that cycle: load rx_data, frame_err, par_err from the new word; rx_valid=1.
  - rx_valid=1 & rx_ready=0: drop the new word, keep the held word and flags, set overrun=1.
- Handshake: rx_valid & rx_ready with no completion -> rx_valid=0 next clk and overrun clears. A simultaneous completion overrides and rx_valid stays 1.
- Error flags are qualified by rx_valid only.
- Break (rxd held 0): frame_err word delivered. No new frame starts until rxd returns high and falls again.
- Config inputs (par_en, par_odd, stop2, baud_div) must be static while busy=1; the block samples them live.
- Async reset mid-frame: all state returns to reset values at once; a partial word is discarded.
- Expected RTL size: 120-400 lines.

Test Plan:
- 8N1, DATA_W=8, baud_div=4, OSR=16 (64 clk/bit), rxd sends 0x55 -> rx_valid rises 1 clk after the STOP1 decision (≈ 9.6 bit times after the start edge); rx_data=0x55, errors=0, busy falls the same clk.
- 8E1, send 0xA5 with parity bit 1 (wrong; correct even parity is 0) -> rx_data=0xA5, par_err=1. Repeat with par_odd=1 -> par_err=0.
- Glitch: rxd low for 3 ticks (12 clk) then high -> START rejects it; no rx_valid; busy returns to 0 within 1 bit time.
- Noise: one tick of inverted rxd at os_cnt=OSR/2 in data bit 3 of 0x0F -> rx_data=0x0F (majority vote absorbs it).
- Frame error and break: send 0x3C with stop bit 0 -> frame_err=1, rx_data=0x3C. Then hold rxd=0 for 20 bits -> exactly one more word (0x00, frame_err=1), then nothing until rxd goes high and falls again.
- Overrun and back-to-back: send 0x11, 0x22, 0x33 with rx_ready=0 -> rx_data stays 0x11, overrun=1 after 0x22. Pulse rx_ready -> rx_valid=0, overrun=0. Then send 0x44 with rx_ready=1 held at completion -> 0x44 loaded, no overrun. Also run a DATA_W=7, stop2=1 instance with 0x7F -> rx_data=0x7F.
